// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve: EX-stage branch outcome, mispredict redirect and timed pipeline flush
module ex_branch_resolve #(
    parameter int size         = 32,
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             Predicted_MPC_i,
    input  logic [2:0]       Branch_sel_i,
    input  logic [size-1:0]  A_i,
    input  logic [size-1:0]  B_i,
    input  logic [size-1:0]  Target_i,
    input  logic [size-1:0]  PCplus_i,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [size-1:0]  redirect_pc_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);
    localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              redirect_q, redirect_d;
    logic [size-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d, mcnt_q, mcnt_d;
    logic              taken, mispredict;

    // actual branch outcome from the selected comparison
    always_comb begin
        taken = Branch_sel_i == 3'b001 ? A_i == B_i :
                Branch_sel_i == 3'b010 ? A_i != B_i :
                Branch_sel_i == 3'b011 ? $signed(A_i) < $signed(B_i) :
                Branch_sel_i == 3'b100 ? $signed(A_i) >= $signed(B_i) :
                Branch_sel_i == 3'b101 ? A_i < B_i :
                Branch_sel_i == 3'b110 ? A_i >= B_i :
                Branch_sel_i == 3'b111;
        mispredict = valid_i & (taken != Predicted_MPC_i);
    end

    // next state: resolve in IDLE, count down the flush window in FLUSH
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        redirect_d = 1'b0;
        pc_d       = pc_q;
        bcnt_d     = bcnt_q;
        mcnt_d     = mcnt_q;
        if (state_q == IDLE) begin
            if (valid_i && Branch_sel_i != 3'b000)
                bcnt_d = &bcnt_q ? bcnt_q : bcnt_q + 1'b1;
            if (mispredict) begin
                mcnt_d     = &mcnt_q ? mcnt_q : mcnt_q + 1'b1;
                redirect_d = 1'b1;
                pc_d       = taken ? Target_i : PCplus_i;
                state_d    = FLUSH;
                fcnt_d     = FW'(FLUSH_CYCLES - 1);
            end
        end else if (fcnt_q == '0) begin
            state_d = IDLE;
        end else begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fcnt_q     <= '0;
            redirect_q <= 1'b0;
            pc_q       <= '0;
            bcnt_q     <= '0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            redirect_q <= redirect_d;
            pc_q       <= pc_d;
            bcnt_q     <= bcnt_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign flush_o       = state_q == FLUSH;
    assign busy_o        = state_q == FLUSH;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = pc_q;
    assign branch_cnt_o  = bcnt_q;
    assign mispred_cnt_o = mcnt_q;
endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb_ex_branch_resolve: directed and randomized checks of ex_branch_resolve against a cycle-level model
module tb_ex_branch_resolve;
    localparam int FC = 2;

    logic        clk = 0, reset = 1, valid = 0, pred = 0;
    logic [2:0]  bsel = 0;
    logic [31:0] a = 0, b = 0, tgt = 0, pcp = 0;
    logic        flush, redir, busy, flush2, redir2, busy2;
    logic [31:0] rpc, rpc2;
    logic [15:0] bc, mc;
    logic [1:0]  bc2, mc2;

    int npass = 0, ntot = 0;

    int          m_fl = 0, m_bc = 0, m_mc = 0, m_bc2 = 0, m_mc2 = 0;
    bit          m_redir = 0;
    logic [31:0] m_pc = 0;

    ex_branch_resolve #(.size(32), .CNT_W(16), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .valid_i(valid), .Predicted_MPC_i(pred), .Branch_sel_i(bsel),
        .A_i(a), .B_i(b), .Target_i(tgt), .PCplus_i(pcp), .flush_o(flush), .redirect_o(redir),
        .redirect_pc_o(rpc), .busy_o(busy), .branch_cnt_o(bc), .mispred_cnt_o(mc));

    ex_branch_resolve #(.size(32), .CNT_W(2), .FLUSH_CYCLES(FC)) dut2 (
        .clk(clk), .reset(reset), .valid_i(valid), .Predicted_MPC_i(pred), .Branch_sel_i(bsel),
        .A_i(a), .B_i(b), .Target_i(tgt), .PCplus_i(pcp), .flush_o(flush2), .redirect_o(redir2),
        .redirect_pc_o(rpc2), .busy_o(busy2), .branch_cnt_o(bc2), .mispred_cnt_o(mc2));

    always #5 clk = ~clk;

    function automatic bit model_taken(logic [2:0] s, logic [31:0] x, logic [31:0] y);
        longint sx = longint'($signed(x)), sy = longint'($signed(y));
        longint ux = longint'(x), uy = longint'(y);
        case (s)
            3'd1: return x == y;
            3'd2: return x != y;
            3'd3: return sx < sy;
            3'd4: return sx >= sy;
            3'd5: return ux < uy;
            3'd6: return ux >= uy;
            3'd7: return 1;
            default: return 0;
        endcase
    endfunction

    // advance the reference model with the current inputs, then clock the DUT
    task automatic cycle();
        bit t;
        t = model_taken(bsel, a, b);
        if (reset) begin
            m_fl = 0; m_redir = 0; m_pc = 0; m_bc = 0; m_mc = 0; m_bc2 = 0; m_mc2 = 0;
        end else if (m_fl > 0) begin
            m_fl--; m_redir = 0;
        end else begin
            m_redir = 0;
            if (valid && bsel != 0) begin
                m_bc = m_bc < 65535 ? m_bc + 1 : m_bc;
                m_bc2 = m_bc2 < 3 ? m_bc2 + 1 : m_bc2;
            end
            if (valid && t != pred) begin
                m_mc = m_mc < 65535 ? m_mc + 1 : m_mc;
                m_mc2 = m_mc2 < 3 ? m_mc2 + 1 : m_mc2;
                m_redir = 1; m_pc = t ? tgt : pcp; m_fl = FC;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drive(bit v, bit p, logic [2:0] s, logic [31:0] x, logic [31:0] y);
        valid = v; pred = p; bsel = s; a = x; b = y;
        tgt = $urandom & 32'hFFFFFFFC; pcp = $urandom & 32'hFFFFFFFC;
    endtask

    task automatic test_reset();
        reset = 1; cycle(); cycle(); reset = 0;
        ntot++; if (flush !== 0 || busy !== 0 || redir !== 0) $display("FAIL reset_ctrl flush=%b busy=%b redir=%b want 000", flush, busy, redir); else npass++;
        ntot++; if (rpc !== 0) $display("FAIL reset_pc got %h want 0", rpc); else npass++;
        ntot++; if (bc !== 0 || mc !== 0) $display("FAIL reset_cnt bc=%0d mc=%0d want 0 0", bc, mc); else npass++;
    endtask

    task automatic test_beq_mispredict();
        logic [31:0] t;
        drive(1, 0, 3'b001, 5, 5); t = tgt; cycle(); drive(0, 0, 0, 0, 0);
        ntot++; if (redir !== 1 || rpc !== t) $display("FAIL beq_redirect redir=%b pc=%h want 1 %h", redir, rpc, t); else npass++;
        ntot++; if (flush !== 1 || busy !== 1) $display("FAIL beq_flush1 flush=%b busy=%b want 1 1", flush, busy); else npass++;
        ntot++; if (bc !== 1 || mc !== 1) $display("FAIL beq_cnt bc=%0d mc=%0d want 1 1", bc, mc); else npass++;
        cycle();
        ntot++; if (redir !== 0 || flush !== 1) $display("FAIL beq_flush2 redir=%b flush=%b want 0 1", redir, flush); else npass++;
        cycle();
        ntot++; if (flush !== 0 || busy !== 0 || rpc !== t) $display("FAIL beq_end flush=%b busy=%b pc=%h want 0 0 %h", flush, busy, rpc, t); else npass++;
    endtask

    task automatic test_signed_unsigned();
        logic [31:0] p;
        drive(1, 1, 3'b011, 32'hFFFFFFFF, 1); cycle();
        ntot++; if (redir !== 0 || flush !== 0) $display("FAIL blt_correct redir=%b flush=%b want 0 0", redir, flush); else npass++;
        ntot++; if (bc !== 16'(m_bc) || mc !== 16'(m_mc)) $display("FAIL blt_cnt bc=%0d mc=%0d want %0d %0d", bc, mc, m_bc, m_mc); else npass++;
        drive(1, 1, 3'b101, 32'hFFFFFFFF, 1); p = pcp; cycle(); drive(0, 0, 0, 0, 0);
        ntot++; if (redir !== 1 || rpc !== p) $display("FAIL bltu_redirect redir=%b pc=%h want 1 %h", redir, rpc, p); else npass++;
        cycle(); cycle();
        ntot++; if (flush !== 0) $display("FAIL bltu_end flush=%b want 0", flush); else npass++;
    endtask

    task automatic test_none_pred_taken();
        logic [31:0] p;
        int b0;
        b0 = m_bc;
        drive(1, 1, 3'b000, 7, 9); p = pcp; cycle(); drive(0, 0, 0, 0, 0);
        ntot++; if (redir !== 1 || rpc !== p) $display("FAIL none_redirect redir=%b pc=%h want 1 %h", redir, rpc, p); else npass++;
        ntot++; if (bc !== 16'(b0) || mc !== 16'(m_mc)) $display("FAIL none_cnt bc=%0d mc=%0d want %0d %0d", bc, mc, b0, m_mc); else npass++;
        cycle(); cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] t;
        drive(1, 0, 3'b111, 0, 0); t = tgt; cycle();
        ntot++; if (redir !== 1 || rpc !== t) $display("FAIL b2b_first redir=%b pc=%h want 1 %h", redir, rpc, t); else npass++;
        for (int i = 0; i < FC; i++) begin
            drive(1, 0, 3'b010, 1, 2); cycle();
            ntot++; if (redir !== 0 || rpc !== t) $display("FAIL b2b_ignore%0d redir=%b pc=%h want 0 %h", i, redir, rpc, t); else npass++;
        end
        ntot++; if (flush !== 0 || bc !== 16'(m_bc) || mc !== 16'(m_mc)) $display("FAIL b2b_cnt flush=%b bc=%0d mc=%0d want 0 %0d %0d", flush, bc, mc, m_bc, m_mc); else npass++;
        drive(1, 1, 3'b100, 1, 2); t = pcp; cycle(); drive(0, 0, 0, 0, 0);
        ntot++; if (redir !== 1 || flush !== 1 || rpc !== t) $display("FAIL b2b_second redir=%b flush=%b pc=%h want 1 1 %h", redir, flush, rpc, t); else npass++;
        cycle(); cycle();
    endtask

    task automatic test_saturate();
        reset = 1; cycle(); reset = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 3'b001, 32'(i), 32'(i)); cycle();
        end
        drive(0, 0, 0, 0, 0);
        ntot++; if (bc2 !== 2'd3 || mc2 !== 2'd0) $display("FAIL sat_cnt2 bc=%0d mc=%0d want 3 0", bc2, mc2); else npass++;
        ntot++; if (bc !== 16'd5 || redir !== 0 || flush !== 0) $display("FAIL sat_cnt16 bc=%0d redir=%b flush=%b want 5 0 0", bc, redir, flush); else npass++;
    endtask

    task automatic test_reset_mid_flush();
        drive(1, 0, 3'b110, 9, 3); cycle(); drive(0, 0, 0, 0, 0);
        ntot++; if (flush !== 1) $display("FAIL midrst_pre flush=%b want 1", flush); else npass++;
        reset = 1; cycle(); reset = 0;
        ntot++; if (flush !== 0 || busy !== 0 || rpc !== 0) $display("FAIL midrst flush=%b busy=%b pc=%h want 0 0 0", flush, busy, rpc); else npass++;
        ntot++; if (bc !== 0 || mc !== 0 || bc2 !== 0 || mc2 !== 0) $display("FAIL midrst_cnt bc=%0d mc=%0d want 0 0", bc, mc); else npass++;
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 400; i++) begin
            x = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : ($urandom_range(0, 1) ? 32'hFFFFFFFC | 32'($urandom_range(0, 3)) : $urandom);
            y = ($urandom_range(0, 3) == 0) ? x : 32'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), x, y);
            reset = $urandom_range(0, 49) == 0;
            cycle();
            ntot++; if (flush !== (m_fl > 0) || busy !== (m_fl > 0) || flush2 !== flush || busy2 !== busy) $display("FAIL rnd%0d_flush flush=%b busy=%b want %b", i, flush, busy, m_fl > 0); else npass++;
            ntot++; if (redir !== m_redir || redir2 !== m_redir || rpc !== m_pc || rpc2 !== m_pc) $display("FAIL rnd%0d_redir redir=%b pc=%h want %b %h", i, redir, rpc, m_redir, m_pc); else npass++;
            ntot++; if (bc !== 16'(m_bc) || mc !== 16'(m_mc)) $display("FAIL rnd%0d_cnt bc=%0d mc=%0d want %0d %0d", i, bc, mc, m_bc, m_mc); else npass++;
            ntot++; if (bc2 !== 2'(m_bc2) || mc2 !== 2'(m_mc2)) $display("FAIL rnd%0d_cnt2 bc=%0d mc=%0d want %0d %0d", i, bc2, mc2, m_bc2, m_mc2); else npass++;
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_beq_mispredict();
        test_signed_unsigned();
        test_none_pred_taken();
        test_back_to_back();
        test_saturate();
        test_reset_mid_flush();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
